// File: rtl/aes_avl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_avl_pkg
// Brief    : Shared state encoding, CTRL/STATUS bit indices and map helpers
//            for the Avalon AES register bank.
// Revision : 1.0 - initial release
// ============================================================================
package aes_avl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_t;

    localparam int c_CTRL_START   = 0;
    localparam int c_CTRL_CLEAR   = 1;
    localparam int c_CTRL_IRQ_EN  = 2;

    localparam int c_STAT_DONE    = 0;
    localparam int c_STAT_BUSY    = 1;
    localparam int c_STAT_WR_ERR  = 2;
    localparam int c_STAT_TIMEOUT = 3;

    // CTRL and STATUS occupy the top two words of the address space.
    function automatic int ctrl_addr(input int addr_w);
        return (1 << addr_w) - 2;
    endfunction

    function automatic int status_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_avl_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : aes_avl_ctrl_fsm
// Brief    : IDLE/RUN/DONE control FSM with RUN-cycle timeout counter.
// Revision : 1.0 - initial release
// ============================================================================
module aes_avl_ctrl_fsm
    import aes_avl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_clear,
    input  logic       i_done,
    output aes_state_t o_state,
    output logic       o_aes_start,
    output logic       o_capture,
    output logic       o_timeout
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    aes_state_t         r_state;
    aes_state_t         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic               r_timeout;
    logic               w_next_timeout;
    logic               w_to_hit;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_to_en
            localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
            assign w_to_hit = (r_cnt == c_TO_LAST);
        end else begin : g_to_dis
            assign w_to_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_timeout <= w_next_timeout;
        end
    end

    // A completion on the same cycle as the timeout hit takes precedence.
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_timeout = r_timeout;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state   = ST_RUN;
                    w_next_cnt     = '0;
                    w_next_timeout = 1'b0;
                end
            end
            ST_RUN: begin
                w_next_cnt = r_cnt + 1'b1;
                if (i_done) begin
                    w_next_state = ST_DONE;
                end else if (w_to_hit) begin
                    w_next_state   = ST_DONE;
                    w_next_timeout = 1'b1;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_next_state   = ST_RUN;
                    w_next_cnt     = '0;
                    w_next_timeout = 1'b0;
                end else if (i_clear) begin
                    w_next_state   = ST_IDLE;
                    w_next_timeout = 1'b0;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_state     = r_state;
        o_aes_start = (r_state == ST_RUN);
        o_capture   = (r_state == ST_RUN) && i_done;
        o_timeout   = r_timeout;
    end

endmodule
`default_nettype wire

// File: rtl/avalon_aes_regbank.sv
`default_nettype none
// ============================================================================
// Module   : avalon_aes_regbank
// Brief    : Avalon-MM register bank for the AES decryption core: key/ENC/DEC
//            words, CTRL/STATUS, timeout; optional IRQ under AES_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_aes_regbank
    import aes_avl_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int KEY_WORDS      = 4,
    parameter int MSG_WORDS      = 4,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          AVL_READ,
    input  logic                          AVL_WRITE,
    input  logic                          AVL_CS,
    input  logic [DATA_W/8-1:0]           AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]             AVL_ADDR,
    input  logic [DATA_W-1:0]             AVL_WRITEDATA,
    output logic [DATA_W-1:0]             AVL_READDATA,
    output logic                          AVL_IRQ,
    output logic                          AES_START,
    input  logic                          AES_DONE,
    output logic [KEY_WORDS*DATA_W-1:0]   AES_KEY,
    output logic [MSG_WORDS*DATA_W-1:0]   AES_MSG_ENC,
    input  logic [MSG_WORDS*DATA_W-1:0]   AES_MSG_DEC,
    output logic [DATA_W-1:0]             EXPORT_DATA
);

    localparam int                c_BYTES     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_ENC_BASE  = ADDR_W'(KEY_WORDS);
    localparam logic [ADDR_W-1:0] c_DEC_BASE  = ADDR_W'(KEY_WORDS + MSG_WORDS);
    localparam logic [ADDR_W-1:0] c_CTRL_ADDR = ADDR_W'(ctrl_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] c_STAT_ADDR = ADDR_W'(status_addr(ADDR_W));

    logic [DATA_W-1:0] r_key [KEY_WORDS];
    logic [DATA_W-1:0] r_enc [MSG_WORDS];
    logic [DATA_W-1:0] r_dec [MSG_WORDS];
    logic [DATA_W-1:0] r_readdata;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_be_mask;
    logic              r_done;
    logic              r_wr_err;
    logic              w_irq_en_rd;
    aes_state_t        w_state;
    logic              w_capture;
    logic              w_timeout;
    logic              w_busy;
    logic              w_wr;
    logic              w_hit_key;
    logic              w_hit_enc;
    logic              w_ctrl_wr;
    logic              w_start_req;
    logic              w_start;
    logic              w_clear;
    logic              w_wr_drop;
    logic              w_data_we;

    always_comb begin
        w_be_mask = '0;
        for (int b = 0; b < c_BYTES; b++) begin
            w_be_mask[b*8 +: 8] = {8{AVL_BYTE_EN[b]}};
        end
    end

    assign w_wr        = AVL_CS && AVL_WRITE;
    assign w_busy      = (w_state == ST_RUN);
    assign w_hit_key   = (AVL_ADDR < c_ENC_BASE);
    assign w_hit_enc   = (AVL_ADDR >= c_ENC_BASE) && (AVL_ADDR < c_DEC_BASE);
    assign w_ctrl_wr   = w_wr && (AVL_ADDR == c_CTRL_ADDR) && AVL_BYTE_EN[0];
    assign w_start_req = w_ctrl_wr && AVL_WRITEDATA[c_CTRL_START];
    assign w_start     = w_start_req && !w_busy;
    // START in the same write suppresses CLEAR entirely.
    assign w_clear     = w_ctrl_wr && AVL_WRITEDATA[c_CTRL_CLEAR] && !AVL_WRITEDATA[c_CTRL_START];
    assign w_wr_drop   = w_busy && w_wr && (w_hit_key || w_hit_enc || w_start_req);
    assign w_data_we   = w_wr && !w_busy;

    aes_avl_ctrl_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ctrl_fsm (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .i_start     (w_start),
        .i_clear     (w_clear),
        .i_done      (AES_DONE),
        .o_state     (w_state),
        .o_aes_start (AES_START),
        .o_capture   (w_capture),
        .o_timeout   (w_timeout)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < KEY_WORDS; i++) r_key[i] <= '0;
            for (int i = 0; i < MSG_WORDS; i++) r_enc[i] <= '0;
            for (int i = 0; i < MSG_WORDS; i++) r_dec[i] <= '0;
        end else begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (w_data_we && (AVL_ADDR == ADDR_W'(i)))
                    r_key[i] <= (r_key[i] & ~w_be_mask) | (AVL_WRITEDATA & w_be_mask);
            end
            for (int i = 0; i < MSG_WORDS; i++) begin
                if (w_data_we && (AVL_ADDR == ADDR_W'(i + KEY_WORDS)))
                    r_enc[i] <= (r_enc[i] & ~w_be_mask) | (AVL_WRITEDATA & w_be_mask);
            end
            if (w_capture) begin
                for (int i = 0; i < MSG_WORDS; i++)
                    r_dec[i] <= AES_MSG_DEC[(MSG_WORDS-1-i)*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_capture)
                r_done <= 1'b1;
            else if (w_start || w_clear)
                r_done <= 1'b0;
            if (w_wr_drop)
                r_wr_err <= 1'b1;
            else if (w_clear)
                r_wr_err <= 1'b0;
        end
    end

`ifdef AES_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_irq_en <= AVL_WRITEDATA[c_CTRL_IRQ_EN];
            r_irq <= (r_done || w_timeout) && r_irq_en;
        end
    end

    assign AVL_IRQ     = r_irq;
    assign w_irq_en_rd = r_irq_en;
`else
    assign AVL_IRQ     = 1'b0;
    assign w_irq_en_rd = 1'b0;
`endif

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < KEY_WORDS; i++)
            if (AVL_ADDR == ADDR_W'(i)) w_rd_data = r_key[i];
        for (int i = 0; i < MSG_WORDS; i++)
            if (AVL_ADDR == ADDR_W'(i + KEY_WORDS)) w_rd_data = r_enc[i];
        for (int i = 0; i < MSG_WORDS; i++)
            if (AVL_ADDR == ADDR_W'(i + KEY_WORDS + MSG_WORDS)) w_rd_data = r_dec[i];
        if (AVL_ADDR == c_CTRL_ADDR)
            w_rd_data[c_CTRL_IRQ_EN] = w_irq_en_rd;
        if (AVL_ADDR == c_STAT_ADDR) begin
            w_rd_data[c_STAT_DONE]    = r_done;
            w_rd_data[c_STAT_BUSY]    = w_busy;
            w_rd_data[c_STAT_WR_ERR]  = r_wr_err;
            w_rd_data[c_STAT_TIMEOUT] = w_timeout;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_readdata <= '0;
        else
            r_readdata <= (AVL_CS && AVL_READ) ? w_rd_data : '0;
    end

    assign AVL_READDATA = r_readdata;

    generate
        for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key_out
            assign AES_KEY[(KEY_WORDS-1-i)*DATA_W +: DATA_W] = r_key[i];
        end
        for (genvar i = 0; i < MSG_WORDS; i++) begin : g_enc_out
            assign AES_MSG_ENC[(MSG_WORDS-1-i)*DATA_W +: DATA_W] = r_enc[i];
        end
    endgenerate

    assign EXPORT_DATA = {r_key[0][DATA_W-1 -: DATA_W/2], r_key[KEY_WORDS-1][DATA_W/2-1:0]};

endmodule
`default_nettype wire
